step1_1_reorder_rot: RTL and testbench
======================================

Name: step1_1_reorder_rot

Overview:
- Stage directly downstream of the stage-1 16-lane butterfly. That butterfly produces A+B and A−B for 16 lanes every valid cycle.
- This block serialises the two results into a single 16-lane stream. Per group, it emits the add beats first, then the buffered sub beats.
- On alternate groups, it applies the trivial radix-2^2 twiddle −j to the sub beats.
- Output feeds the stage-2 shift-register/butterfly.

Parameters:
- BLK_CLK, 2: beats per group; equals the upstream shift-register depth.
- IN_W, 12: input sample width, signed.
- OUT_W, 13: output sample width, signed. Must be at least IN_W+1 so that −j of −2048 is exact.
- LANES, 16: samples per beat.

Ports:
- clk, in, 1: rising-edge clock.
- rstn, in, 1: synchronous, active-high reset. Asserted when 1, sampled on the clk edge.
- din_valid, in, 1: input beat valid.
- din_add_r / din_add_i, in, LANES x IN_W: A+B real/imag.
- din_sub_r / din_sub_i, in, LANES x IN_W: A−B real/imag.
- dout_valid, out, 1: output beat valid.
- dout_r / dout_i, out, LANES x OUT_W: output sample real/imag.
- dout_is_sub, out, 1: 0 = add beat, 1 = sub beat.
- dout_grp_last, out, 1: high on the final sub beat of a group.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, beat counter 0, grp_odd 0, sub buffer cleared to 0.
- FSM states:
  - IDLE: din_valid → ADD, beat captured as beat 0.
  - ADD: each din_valid beat increments the counter. When the beat with counter == BLK_CLK−1 is accepted → SUB, counter reset to 0.
  - SUB: one buffered beat emitted per cycle, no stall. After beat BLK_CLK−1 is emitted → IDLE and grp_odd toggles.
- ADD path, latency 1: accepted beat at edge t → dout_valid=1, dout_is_sub=0 and dout = sign-extended add values after edge t+1.
- Sub capture: the same beat's sub values are written to buffer[counter] (BLK_CLK x LANES x 2 x IN_W).
- din_valid gaps inside ADD: the gap cycle gives dout_valid=0, state and counter hold, no timeout.
- SUB output:
  - First sub beat appears the cycle after the last add beat is output. Sub beats follow back-to-back in capture order.
  - grp_odd = 0: output = sign-extended (sub_r, sub_i).
  - grp_odd = 1: output = (sub_i, −sub_r), with negation done at OUT_W width. −(−2048) = +2048, no saturation.
- dout_grp_last = 1 together with the sub beat of index BLK_CLK−1.
- din_valid while in SUB: the beat is dropped. Buffer and state are unaffected. Counted as an overflow (see optional feature).
- Upstream contract: at least BLK_CLK idle cycles between groups.
- din_valid in the cycle the FSM returns to IDLE is accepted normally as beat 0 of the next group.
- Mid-operation reset: the partial group is discarded, no further outputs appear, and grp_odd restarts at 0.
- dout values while dout_valid = 0: hold the last value.

Optional Feature:
- Macro: STEP1_1_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf_flag (1 bit, sticky), set on any beat dropped in SUB and cleared only by rstn.
  - Adds output port ovf_cnt (8 bits), a saturating count of dropped beats.
- When undefined: neither port exists and dropped beats are silently discarded.

Test Plan:
- Reset then one group, 2 beats: lane0 add = (100, −5), sub = (7, −2048). Expect:
  - add beats out at t+1, t+2;
  - sub beats out at t+3, t+4 with lane0 = (7, −2048);
  - dout_grp_last at t+4.
- Second group, same data: sub lane0 = (−2048, −7), i.e. the −j rotation. Third group returns to unrotated output.
- Gap inside ADD: beat0, 3 idle cycles, beat1 → add outputs separated by the gap. Sub beats follow beat1's output back-to-back.
- din_valid asserted during SUB → that beat is dropped and outputs are unchanged. With STEP1_1_OVF_FLAG_EN: ovf_flag=1, ovf_cnt=1.
- rstn pulsed after the first add beat → all outputs 0 next cycle, busy=0. A following group is treated with grp_odd=0.
- Extremes: sub = (−2048, 2047) on an odd group → output (2047, 2048), no wrap.

Source files
------------

// File: rtl/step1_1_reorder_rot.sv
// Serialises the stage-1 butterfly add/sub results into one LANES-wide stream: add beats first,
// then buffered sub beats, rotated by -j on odd groups. Macro STEP1_1_OVF_FLAG_EN adds ovf_flag/ovf_cnt.

module step1_1_reorder_rot_lane #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 13
) (
   input  logic             sel_sub_i,
   input  logic             rot_i,
   input  logic [IN_W-1:0]  add_r_i,
   input  logic [IN_W-1:0]  add_i_i,
   input  logic [IN_W-1:0]  sub_r_i,
   input  logic [IN_W-1:0]  sub_i_i,
   output logic [OUT_W-1:0] r_o,
   output logic [OUT_W-1:0] i_o
);
   logic [OUT_W-1:0] ar, ai, sr, si;

   assign ar = {{(OUT_W-IN_W){add_r_i[IN_W-1]}}, add_r_i};
   assign ai = {{(OUT_W-IN_W){add_i_i[IN_W-1]}}, add_i_i};
   assign sr = {{(OUT_W-IN_W){sub_r_i[IN_W-1]}}, sub_r_i};
   assign si = {{(OUT_W-IN_W){sub_i_i[IN_W-1]}}, sub_i_i};

   always_comb begin
      r_o = ar;
      i_o = ai;
      if (sel_sub_i) begin
         if (rot_i) begin
            // Negating after widening keeps -(-2^(IN_W-1)) exact
            r_o = si;
            i_o = -sr;
         end else begin
            r_o = sr;
            i_o = si;
         end
      end
   end
endmodule

module step1_1_reorder_rot #(
   parameter int BLK_CLK = 2,
   parameter int IN_W    = 12,
   parameter int OUT_W   = 13,
   parameter int LANES   = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         din_valid,
   input  logic [LANES-1:0][IN_W-1:0]   din_add_r,
   input  logic [LANES-1:0][IN_W-1:0]   din_add_i,
   input  logic [LANES-1:0][IN_W-1:0]   din_sub_r,
   input  logic [LANES-1:0][IN_W-1:0]   din_sub_i,
   output logic                         dout_valid,
   output logic [LANES-1:0][OUT_W-1:0]  dout_r,
   output logic [LANES-1:0][OUT_W-1:0]  dout_i,
   output logic                         dout_is_sub,
   output logic                         dout_grp_last,
`ifdef STEP1_1_OVF_FLAG_EN
   output logic                         ovf_flag,
   output logic [7:0]                   ovf_cnt,
`endif
   output logic                         busy
);
   localparam int CNT_W = (BLK_CLK > 1) ? $clog2(BLK_CLK) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_CLK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_SUB  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             odd_q, odd_d;
   logic             vld_q, vld_d;
   logic             sub_q, sub_d;
   logic             last_q, last_d;
   logic             wr_en, sel_sub, drop;

   logic [LANES-1:0][IN_W-1:0]  buf_r_q [BLK_CLK];
   logic [LANES-1:0][IN_W-1:0]  buf_i_q [BLK_CLK];
   logic [LANES-1:0][OUT_W-1:0] dr_q, di_q, dr_d, di_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      odd_d   = odd_q;
      vld_d   = 1'b0;
      sub_d   = 1'b0;
      last_d  = 1'b0;
      wr_en   = 1'b0;
      sel_sub = 1'b0;
      drop    = 1'b0;
      case (state_q)
         S_IDLE, S_ADD: begin
            if (din_valid) begin
               wr_en = 1'b1;
               vld_d = 1'b1;
               if (cnt_q == LAST) begin
                  state_d = S_SUB;
                  cnt_d   = '0;
               end else begin
                  state_d = S_ADD;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         S_SUB: begin
            // Upstream should be idle here; anything arriving is discarded
            drop    = din_valid;
            sel_sub = 1'b1;
            vld_d   = 1'b1;
            sub_d   = 1'b1;
            if (cnt_q == LAST) begin
               last_d  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
               odd_d   = ~odd_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      step1_1_reorder_rot_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
         .sel_sub_i (sel_sub),
         .rot_i     (odd_q),
         .add_r_i   (din_add_r[g]),
         .add_i_i   (din_add_i[g]),
         .sub_r_i   (buf_r_q[cnt_q][g]),
         .sub_i_i   (buf_i_q[cnt_q][g]),
         .r_o       (dr_d[g]),
         .i_o       (di_d[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         odd_q   <= 1'b0;
         vld_q   <= 1'b0;
         sub_q   <= 1'b0;
         last_q  <= 1'b0;
         dr_q    <= '0;
         di_q    <= '0;
         for (int b = 0; b < BLK_CLK; b++) begin
            buf_r_q[b] <= '0;
            buf_i_q[b] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         odd_q   <= odd_d;
         vld_q   <= vld_d;
         sub_q   <= sub_d;
         last_q  <= last_d;
         if (vld_d) begin
            dr_q <= dr_d;
            di_q <= di_d;
         end
         if (wr_en) begin
            buf_r_q[cnt_q] <= din_sub_r;
            buf_i_q[cnt_q] <= din_sub_i;
         end
      end
   end

`ifdef STEP1_1_OVF_FLAG_EN
   logic       ovf_flag_q;
   logic [7:0] ovf_cnt_q;

   always_ff @(posedge clk) begin
      if (rstn) begin
         ovf_flag_q <= 1'b0;
         ovf_cnt_q  <= '0;
      end else if (drop) begin
         ovf_flag_q <= 1'b1;
         if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
   end

   assign ovf_flag = ovf_flag_q;
   assign ovf_cnt  = ovf_cnt_q;
`endif

   assign dout_valid    = vld_q;
   assign dout_r        = dr_q;
   assign dout_i        = di_q;
   assign dout_is_sub   = sub_q;
   assign dout_grp_last = last_q;
   assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_step1_1_reorder_rot.sv
// Bench for step1_1_reorder_rot: a per-cycle expectation timeline built from the group rules,
// compared against the DUT on every negedge, plus literal lane-0 pins.

module tb_step1_1_reorder_rot;
   localparam int BLK   = 2;
   localparam int IN_W  = 12;
   localparam int OUT_W = 13;
   localparam int LANES = 16;
   localparam int N     = 256;

   logic clk = 1'b0;
   logic rstn, din_valid;
   logic [LANES-1:0][IN_W-1:0]  din_add_r, din_add_i, din_sub_r, din_sub_i;
   logic                        dout_valid, dout_is_sub, dout_grp_last, busy;
   logic [LANES-1:0][OUT_W-1:0] dout_r, dout_i;
`ifdef STEP1_1_OVF_FLAG_EN
   logic                        ovf_flag;
   logic [7:0]                  ovf_cnt;
`endif

   step1_1_reorder_rot #(.BLK_CLK(BLK), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .din_valid     (din_valid),
      .din_add_r     (din_add_r),
      .din_add_i     (din_add_i),
      .din_sub_r     (din_sub_r),
      .din_sub_i     (din_sub_i),
      .dout_valid    (dout_valid),
      .dout_r        (dout_r),
      .dout_i        (dout_i),
      .dout_is_sub   (dout_is_sub),
      .dout_grp_last (dout_grp_last),
`ifdef STEP1_1_OVF_FLAG_EN
      .ovf_flag      (ovf_flag),
      .ovf_cnt       (ovf_cnt),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs indexed by the cycle in which they must be visible
   logic exp_vld [N];
   logic exp_sub [N];
   logic exp_last[N];
   logic exp_busy[N];
   logic exp_rst [N];
   int   exp_ovf [N];
   logic [LANES-1:0][OUT_W-1:0] exp_r[N];
   logic [LANES-1:0][OUT_W-1:0] exp_i[N];

   int pin_c[4];
   int pin_r[4];
   int pin_i[4];

   int m_cnt, m_sub_until, m_odd, m_ovf;
   int bsr[BLK][LANES];
   int bsi[BLK][LANES];

   int n_cmp = 0;
   int n_bad = 0;
   logic [LANES-1:0][OUT_W-1:0] hr, hi;

   function automatic int lv(input int b, input int l, input int s);
      return (l == 0) ? b : b + s * 16 + l * 7;
   endfunction

   function automatic int sx(input int v);
      logic signed [IN_W-1:0] t;
      t = v[IN_W-1:0];
      return int'(t);
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < N) begin
         if (exp_rst[cyc]) begin
            hr = '0;
            hi = '0;
         end else if (exp_vld[cyc]) begin
            hr = exp_r[cyc];
            hi = exp_i[cyc];
         end
         chk("dout_valid", dout_valid, exp_vld[cyc]);
         chk("dout_is_sub", dout_is_sub, exp_sub[cyc]);
         chk("dout_grp_last", dout_grp_last, exp_last[cyc]);
         chk("busy", busy, exp_busy[cyc]);
         chk("dout_r", dout_r, hr);
         chk("dout_i", dout_i, hi);
`ifdef STEP1_1_OVF_FLAG_EN
         chk("ovf_flag", ovf_flag, exp_ovf[cyc] > 0);
         chk("ovf_cnt", ovf_cnt, 8'(exp_ovf[cyc]));
`endif
         for (int p = 0; p < 4; p++) begin
            if (cyc == pin_c[p]) begin
               logic [OUT_W-1:0] tr, ti;
               tr = pin_r[p][OUT_W-1:0];
               ti = pin_i[p][OUT_W-1:0];
               chk("pin_lane0_r", dout_r[0], tr);
               chk("pin_lane0_i", dout_i[0], ti);
            end
         end
      end
   end

   // Drive one cycle's inputs, fold them into the expectation timeline, advance one clock
   task automatic tick(input bit v, input bit r, input int ar, input int ai,
                       input int sr, input int si, input int salt);
      int c;
      c = cyc;
      rstn      = r;
      din_valid = v && !r;
      for (int l = 0; l < LANES; l++) begin
         din_add_r[l] = IN_W'(lv(ar, l, salt));
         din_add_i[l] = IN_W'(lv(ai, l, salt));
         din_sub_r[l] = IN_W'(lv(sr, l, salt));
         din_sub_i[l] = IN_W'(lv(si, l, salt));
      end
      if (r) begin
         m_cnt = 0; m_sub_until = -1; m_odd = 0; m_ovf = 0;
         for (int k = c + 1; k < N; k++) begin
            exp_vld[k] = 1'b0; exp_sub[k] = 1'b0; exp_last[k] = 1'b0;
         end
         exp_rst[c+1] = 1'b1;
      end else if (v) begin
         if (c <= m_sub_until) begin
            m_ovf = (m_ovf == 255) ? 255 : m_ovf + 1;
         end else begin
            exp_vld[c+1] = 1'b1;
            for (int l = 0; l < LANES; l++) begin
               exp_r[c+1][l] = OUT_W'(sx(lv(ar, l, salt)));
               exp_i[c+1][l] = OUT_W'(sx(lv(ai, l, salt)));
               bsr[m_cnt][l] = sx(lv(sr, l, salt));
               bsi[m_cnt][l] = sx(lv(si, l, salt));
            end
            m_cnt++;
            if (m_cnt == BLK) begin
               for (int b = 0; b < BLK; b++) begin
                  int k;
                  k = c + 2 + b;
                  exp_vld[k]  = 1'b1;
                  exp_sub[k]  = 1'b1;
                  exp_last[k] = (b == BLK - 1);
                  for (int l = 0; l < LANES; l++) begin
                     exp_r[k][l] = OUT_W'(m_odd ? bsi[b][l] : bsr[b][l]);
                     exp_i[k][l] = OUT_W'(m_odd ? -bsr[b][l] : bsi[b][l]);
                  end
               end
               m_sub_until = c + BLK;
               m_cnt = 0;
               m_odd ^= 1;
            end
         end
      end
      exp_busy[c+1] = (m_cnt > 0) || (c + 1 <= m_sub_until);
      exp_ovf[c+1]  = m_ovf;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rstn = 1'b1; din_valid = 1'b0;
      din_add_r = '0; din_add_i = '0; din_sub_r = '0; din_sub_i = '0;
      hr = '0; hi = '0;
      m_cnt = 0; m_sub_until = -1; m_odd = 0; m_ovf = 0;
      for (int k = 0; k < N; k++) begin
         exp_vld[k] = 0; exp_sub[k] = 0; exp_last[k] = 0; exp_busy[k] = 0;
         exp_rst[k] = 0; exp_ovf[k] = 0; exp_r[k] = '0; exp_i[k] = '0;
      end
      for (int p = 0; p < 4; p++) begin
         pin_c[p] = -1; pin_r[p] = 0; pin_i[p] = 0;
      end

      tick(0, 1, 0, 0, 0, 0, 0);
      idle(2);

      // Group 1, even: unrotated sub
      pin_c[0] = cyc + 3; pin_r[0] = 7; pin_i[0] = -2048;
      tick(1, 0, 100, -5, 7, -2048, 1);
      tick(1, 0, 100, -5, 7, -2048, 2);
      idle(3);

      // Group 2, odd: rotated by -j; group 3 starts on the IDLE-return cycle
      pin_c[1] = cyc + 3; pin_r[1] = -2048; pin_i[1] = -7;
      tick(1, 0, 100, -5, 7, -2048, 3);
      tick(1, 0, 100, -5, 7, -2048, 4);
      idle(2);
      pin_c[2] = cyc + 3; pin_r[2] = 7; pin_i[2] = -2048;
      tick(1, 0, 100, -5, 7, -2048, 5);
      tick(1, 0, 100, -5, 7, -2048, 6);
      idle(3);

      // Group 4, odd: valid gap inside ADD
      tick(1, 0, -300, 411, 55, -66, 7);
      idle(3);
      tick(1, 0, 1000, -1000, -77, 88, 8);
      idle(3);

      // Group 5, even: beat during SUB is dropped
      tick(1, 0, 12, 34, 56, 78, 9);
      tick(1, 0, -12, -34, -56, -78, 10);
      tick(1, 0, 555, 555, 555, 555, 11);
      idle(3);

      // Group 6 aborted by reset after first add beat
      tick(1, 0, 200, 201, 202, 203, 12);
      tick(0, 1, 0, 0, 0, 0, 0);
      idle(2);

      // Group 7 even after reset, group 8 odd with extreme sub values
      tick(1, 0, 9, -9, 2000, -2000, 13);
      tick(1, 0, -9, 9, -2000, 2000, 14);
      idle(3);
      pin_c[3] = cyc + 3; pin_r[3] = 2047; pin_i[3] = 2048;
      tick(1, 0, 2047, -2048, -2048, 2047, 15);
      tick(1, 0, -2048, 2047, -2048, 2047, 16);
      idle(4);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
